// File: rtl/hex_frame_pkg.sv
// Shared types and constants for the UART hex frame controller.
package hex_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WAIT_CONV,
        FLUSH,
        HOLD
    } state_e;

    typedef enum logic [2:0] {
        CLS_HEX,
        CLS_WS,
        CLS_START,
        CLS_END,
        CLS_OTHER
    } char_cls_e;

    localparam logic [1:0] ERR_OVERRUN = 2'b00;
    localparam logic [1:0] ERR_NONHEX  = 2'b01;
    localparam logic [1:0] ERR_LENGTH  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] WS_SPACE = 8'h20;
    localparam logic [7:0] WS_CR    = 8'h0D;
    localparam logic [7:0] PAD_CHAR = 8'h30;

endpackage

// File: rtl/hex_char_classifier.sv
// Combinational classification of a received ASCII byte.
module hex_char_classifier
    import hex_frame_pkg::*;
#(
    parameter logic [7:0] START_CHAR = 8'h3A,
    parameter logic [7:0] END_CHAR   = 8'h0A
) (
    input  logic [7:0] byte_i,
    output logic [2:0] cls_o
);

    // Framing characters win so a frame delimiter can never be taken as data.
    always_comb begin
        cls_o = CLS_OTHER;
        if (byte_i == START_CHAR) begin
            cls_o = CLS_START;
        end else if (byte_i == END_CHAR) begin
            cls_o = CLS_END;
        end else if ((byte_i >= 8'h30 && byte_i <= 8'h39) ||
                     (byte_i >= 8'h41 && byte_i <= 8'h46) ||
                     (byte_i >= 8'h61 && byte_i <= 8'h66)) begin
            cls_o = CLS_HEX;
        end else if (byte_i == WS_SPACE || byte_i == WS_CR) begin
            cls_o = CLS_WS;
        end
    end

endmodule

// File: rtl/hex_frame_controller.sv
// Filters UART bytes into hex digits for the converter, assembles the frame
// word, reports framing errors and keeps the converter's digit pairing aligned.
module hex_frame_controller
    import hex_frame_pkg::*;
#(
    parameter int         NUM_BYTES      = 4,
    parameter logic [7:0] START_CHAR     = 8'h3A,
    parameter logic [7:0] END_CHAR       = 8'h0A,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_byte,
    output logic                   conv_valid,
    output logic [7:0]             conv_byte,
    input  logic                   conv_ready,
    input  logic [7:0]             conv_out,
    output logic [8*NUM_BYTES-1:0] frame_data,
    output logic                   frame_valid,
    input  logic                   frame_ack,
    output logic                   err_valid,
    output logic [1:0]             err_code,
    output logic                   busy
);

    localparam int DW = $clog2(2*NUM_BYTES+2);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int BW = $clog2(NUM_BYTES+1);
    localparam logic [DW-1:0] DIGITS = DW'(2*NUM_BYTES);
    localparam logic [BW-1:0] NBYTES = BW'(NUM_BYTES);
    localparam logic [TW-1:0] TMAX   = TW'(TIMEOUT_CYCLES-1);

    state_e                 state_q, state_d;
    logic [DW-1:0]          digit_q, digit_d;
    logic [BW-1:0]          byte_q, byte_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [8*NUM_BYTES-1:0] frame_q, frame_d;
    logic                   cv_q, cv_d;
    logic [7:0]             cb_q, cb_d;
    logic                   fv_q, fv_d;
    logic                   ev_q, ev_d;
    logic [1:0]             ec_q, ec_d;
    logic                   abort;
    logic [1:0]             abort_code;
    logic [2:0]             cls_raw;
    char_cls_e              cls;

    hex_char_classifier #(
        .START_CHAR(START_CHAR),
        .END_CHAR  (END_CHAR)
    ) u_cls (
        .byte_i(rx_byte),
        .cls_o (cls_raw)
    );

    assign cls = char_cls_e'(cls_raw);

    always_comb begin
        state_d    = state_q;
        digit_d    = digit_q;
        byte_d     = byte_q;
        timer_d    = (timer_q == TMAX) ? timer_q : timer_q + 1'b1;
        frame_d    = frame_q;
        cv_d       = 1'b0;
        cb_d       = cb_q;
        fv_d       = fv_q;
        ev_d       = 1'b0;
        ec_d       = ec_q;
        abort      = 1'b0;
        abort_code = ERR_OVERRUN;

        unique case (state_q)
            IDLE: begin
                if (rx_valid && cls == CLS_START) begin
                    digit_d = '0;
                    byte_d  = '0;
                    timer_d = '0;
                    frame_d = '0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (rx_valid) begin
                    unique case (cls)
                        CLS_HEX: begin
                            if (digit_q == DIGITS) begin
                                abort      = 1'b1;
                                abort_code = ERR_LENGTH;
                            end else begin
                                cv_d    = 1'b1;
                                cb_d    = rx_byte;
                                digit_d = digit_q + 1'b1;
                                timer_d = '0;
                                if (digit_q[0]) state_d = WAIT_CONV;
                            end
                        end
                        CLS_WS: timer_d = '0;
                        CLS_END: begin
                            if (digit_q == DIGITS && byte_q == NBYTES) begin
                                fv_d    = 1'b1;
                                state_d = HOLD;
                            end else begin
                                abort      = 1'b1;
                                abort_code = ERR_LENGTH;
                            end
                        end
                        CLS_START: begin
                            abort      = 1'b1;
                            abort_code = ERR_LENGTH;
                        end
                        default: begin
                            abort      = 1'b1;
                            abort_code = ERR_NONHEX;
                        end
                    endcase
                end else if (timer_q == TMAX) begin
                    abort      = 1'b1;
                    abort_code = ERR_TIMEOUT;
                end
            end
            WAIT_CONV: begin
                if (conv_ready) begin
                    frame_d = {frame_q[8*NUM_BYTES-9:0], conv_out};
                    byte_d  = byte_q + 1'b1;
                    state_d = COLLECT;
                end
                if (rx_valid) begin
                    abort      = 1'b1;
                    abort_code = ERR_OVERRUN;
                end else if (!conv_ready && timer_q == TMAX) begin
                    abort      = 1'b1;
                    abort_code = ERR_TIMEOUT;
                end
            end
            FLUSH: begin
                if (conv_ready) state_d = IDLE;
            end
            HOLD: begin
                if (rx_valid) begin
                    ev_d = 1'b1;
                    ec_d = ERR_OVERRUN;
                end
                if (frame_ack) begin
                    fv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A half-sent pair gets a pad digit so the converter emits one byte
        // we can discard; an outstanding pair only needs its result drained.
        if (abort) begin
            ev_d = 1'b1;
            ec_d = abort_code;
            if (state_q == COLLECT && digit_q[0]) begin
                cv_d    = 1'b1;
                cb_d    = PAD_CHAR;
                state_d = FLUSH;
            end else if (state_q == WAIT_CONV && !conv_ready) begin
                state_d = FLUSH;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            digit_q <= '0;
            byte_q  <= '0;
            timer_q <= '0;
            frame_q <= '0;
            cv_q    <= 1'b0;
            cb_q    <= '0;
            fv_q    <= 1'b0;
            ev_q    <= 1'b0;
            ec_q    <= '0;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            byte_q  <= byte_d;
            timer_q <= timer_d;
            frame_q <= frame_d;
            cv_q    <= cv_d;
            cb_q    <= cb_d;
            fv_q    <= fv_d;
            ev_q    <= ev_d;
            ec_q    <= ec_d;
        end
    end

    assign conv_valid  = cv_q;
    assign conv_byte   = cb_q;
    assign frame_data  = frame_q;
    assign frame_valid = fv_q;
    assign err_valid   = ev_q;
    assign err_code    = ec_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_hex_frame_controller.sv
// Directed bench: table of frames with expected results plus hand-built
// sequences for hold/overrun, end-of-frame latency and asynchronous reset.
module tb_hex_frame_controller;

    localparam int NB = 4;
    localparam int NV = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          conv_valid;
    logic [7:0]    conv_byte;
    logic          conv_ready = 1'b0;
    logic [7:0]    conv_out = 8'h00;
    logic [8*NB-1:0] frame_data;
    logic          frame_valid;
    logic          frame_ack = 1'b0;
    logic          err_valid;
    logic [1:0]    err_code;
    logic          busy;

    int checks = 0;
    int errors = 0;

    hex_frame_controller #(
        .NUM_BYTES     (NB),
        .START_CHAR    (8'h3A),
        .END_CHAR      (8'h0A),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .conv_valid(conv_valid), .conv_byte(conv_byte),
        .conv_ready(conv_ready), .conv_out(conv_out),
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_ack(frame_ack),
        .err_valid(err_valid), .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] hexval(input logic [7:0] c);
        if (c >= "0" && c <= "9") return 4'(c - "0");
        if (c >= "A" && c <= "F") return 4'(c - "A" + 10);
        return 4'(c - "a" + 10);
    endfunction

    // Ideal converter: pairs digits, result appears two cycles after the
    // second digit's strobe is seen. No reset, like the real part.
    int         nconv = 0;
    bit         have_hi = 1'b0;
    logic [3:0] hi_nib;
    bit         pend = 1'b0;
    logic [7:0] pend_val;
    always @(negedge clk) begin
        if (pend) begin
            conv_ready = 1'b1;
            conv_out   = pend_val;
            pend       = 1'b0;
        end else begin
            conv_ready = 1'b0;
        end
        if (conv_valid) begin
            nconv++;
            if (!have_hi) begin
                hi_nib  = hexval(conv_byte);
                have_hi = 1'b1;
            end else begin
                pend_val = {hi_nib, hexval(conv_byte)};
                pend     = 1'b1;
                have_hi  = 1'b0;
            end
        end
    end

    int         nerr = 0;
    logic [1:0] last_code = 2'b00;
    always @(negedge clk) begin
        if (err_valid) begin
            nerr++;
            last_code = err_code;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        idle(4);
    endtask

    // '^' stands in for a carriage return inside the string tables.
    task automatic send_str(input string s);
        logic [7:0] b;
        for (int k = 0; k < s.len(); k++) begin
            b = s[k];
            if (b == "^") b = 8'h0D;
            send_byte(b);
        end
    endtask

    task automatic ack_frame(input string tag);
        @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        chk({tag, " fv_after_ack"}, 64'(frame_valid), 64'd0);
        chk({tag, " busy_after_ack"}, 64'(busy), 64'd0);
    endtask

    typedef struct {
        int          idle_after;
        bit          frm;
        logic [31:0] data;
        int          errs;
        logic [1:0]  code;
        int          convs;
    } vec_t;

    string vs[NV];
    vec_t  vt[NV];

    initial begin
        int    e0, c0;
        string tag;

        vs[0] = ":DEADBEEF\n";   vt[0] = '{10, 1'b1, 32'hDEADBEEF, 0, 2'b00, 8};
        vs[1] = ":12 34^ ab CD\n"; vt[1] = '{10, 1'b1, 32'h1234ABCD, 0, 2'b00, 8};
        vs[2] = ":12G";          vt[2] = '{10, 1'b0, 32'h0, 1, 2'b01, 2};
        vs[3] = ":00000001\n";   vt[3] = '{10, 1'b1, 32'h00000001, 0, 2'b00, 8};
        vs[4] = ":123";          vt[4] = '{70, 1'b0, 32'h0, 1, 2'b11, 4};
        vs[5] = ":CAFEF00D\n";   vt[5] = '{10, 1'b1, 32'hCAFEF00D, 0, 2'b00, 8};
        vs[6] = ":123456\n";     vt[6] = '{10, 1'b0, 32'h0, 1, 2'b10, 6};
        vs[7] = ":1234567890\n"; vt[7] = '{10, 1'b0, 32'h0, 1, 2'b10, 8};
        vs[8] = ":1:";           vt[8] = '{10, 1'b0, 32'h0, 1, 2'b10, 2};
        vs[9] = ":ABCDEF01\n";   vt[9] = '{10, 1'b1, 32'hABCDEF01, 0, 2'b00, 8};

        idle(3);
        chk("reset outputs",
            64'({conv_valid, conv_byte, frame_data, frame_valid, err_valid, err_code, busy}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < NV; i++) begin
            tag = $sformatf("vec%0d", i);
            e0 = nerr;
            c0 = nconv;
            send_str(vs[i]);
            idle(vt[i].idle_after);
            chk({tag, " err_count"}, 64'(nerr - e0), 64'(vt[i].errs));
            if (vt[i].errs != 0) chk({tag, " err_code"}, 64'(last_code), 64'(vt[i].code));
            chk({tag, " conv_count"}, 64'(nconv - c0), 64'(vt[i].convs));
            chk({tag, " frame_valid"}, 64'(frame_valid), 64'(vt[i].frm));
            chk({tag, " conv_aligned"}, 64'(have_hi), 64'd0);
            if (vt[i].frm) begin
                chk({tag, " frame_data"}, 64'(frame_data), 64'(vt[i].data));
                ack_frame(tag);
            end else begin
                chk({tag, " busy_idle"}, 64'(busy), 64'd0);
            end
        end

        // End-of-frame latency, long hold, overrun while holding.
        send_str(":DEADBEEF");
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = 8'h0A;
        chk("eof fv_before_edge", 64'(frame_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("eof fv_after_edge", 64'(frame_valid), 64'd1);
        @(negedge clk);
        rx_valid = 1'b0;
        idle(20);
        chk("hold fv", 64'(frame_valid), 64'd1);
        e0 = nerr;
        send_byte(8'h3A);
        chk("hold overrun count", 64'(nerr - e0), 64'd1);
        chk("hold overrun code", 64'(last_code), 64'(2'b00));
        chk("hold data", 64'(frame_data), 64'hDEADBEEF);
        chk("hold fv kept", 64'(frame_valid), 64'd1);
        chk("hold busy", 64'(busy), 64'd1);
        ack_frame("hold");

        // Asynchronous reset in the middle of a frame, converter even-aligned.
        send_str(":12");
        idle(2);
        chk("mid busy", 64'(busy), 64'd1);
        chk("mid partial", 64'(frame_data), 64'h12);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async reset outputs",
            64'({conv_valid, conv_byte, frame_data, frame_valid, err_valid, err_code, busy}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        e0 = nerr;
        send_str(":0BADF00D\n");
        idle(5);
        chk("post-reset err", 64'(nerr - e0), 64'd0);
        chk("post-reset fv", 64'(frame_valid), 64'd1);
        chk("post-reset data", 64'(frame_data), 64'h0BADF00D);
        ack_frame("post-reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
